// File: rtl/top_fft_pkg.sv
// Shared constants and elaboration-time helpers for the parallel radix-2 FFT:
// width rules, index bit reversal and the Q2.FRAC twiddle ROM functions.
package top_fft_pkg;

  localparam int DEF_POINT_FFT_POW2 = 4;
  localparam int DEF_FRAC_BITS      = 15;
  localparam real PI                = 3.14159265358979323846;

  function automatic int data_in_w(input int frac_bits);
    return frac_bits + 32'sd1;
  endfunction

  function automatic int data_out_w(input int frac_bits, input int pow2);
    return frac_bits + pow2 + 32'sd1;
  endfunction

  function automatic int bit_reverse(input int idx, input int nbits);
    int rev;
    rev = 32'sd0;
    for (int i = 0; i < nbits; i++) begin
      rev = (rev << 1) | ((idx >> i) & 32'sd1);
    end
    return rev;
  endfunction

  // Taylor series keeps the ROM independent of tool support for $sin/$cos
  function automatic real sin_cos(input real x, input bit want_sin);
    real term;
    real sum;
    int  k;
    term = want_sin ? x : 1.0;
    sum  = term;
    for (int i = 1; i < 18; i++) begin
      k    = want_sin ? 32'sd2 * i : 32'sd2 * i - 32'sd1;
      term = -term * x * x / (real'(k) * real'(k + 32'sd1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic int round_q(input real v, input int frac_bits);
    real s;
    s = v * real'(32'sd1 << frac_bits);
    return (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
  endfunction

  function automatic int twiddle_re(input int m, input int n, input int frac_bits);
    return round_q(sin_cos(2.0 * PI * real'(m) / real'(n), 1'b0), frac_bits);
  endfunction

  function automatic int twiddle_im(input int m, input int n, input int frac_bits);
    return round_q(-sin_cos(2.0 * PI * real'(m) / real'(n), 1'b1), frac_bits);
  endfunction

endpackage

// File: rtl/top_fft_if.sv
// Frame-in / spectrum-out bundle of the FFT; master drives frames, slave is the engine.
interface top_fft_if
  import top_fft_pkg::*;
#(
  parameter int POINT_FFT  = 1 << DEF_POINT_FFT_POW2,
  parameter int DATA_IN_W  = data_in_w(DEF_FRAC_BITS),
  parameter int DATA_OUT_W = data_out_w(DEF_FRAC_BITS, DEF_POINT_FFT_POW2)
) ();

  logic                                       valid_i;
  logic [POINT_FFT-1:0][1:0][DATA_IN_W-1:0]   data_i;
  logic                                       valid_o;
  logic [POINT_FFT-1:0][1:0][DATA_OUT_W-1:0]  data_o;

  modport master (output valid_i, output data_i, input valid_o, input data_o);
  modport slave  (input valid_i, input data_i, output valid_o, output data_o);

endinterface

// File: rtl/fft_butterfly.sv
// Combinational radix-2 DIT butterfly: A' = A + W*B, B' = A - W*B, one bit of growth.
// TOP_FFT_ROUND_EN selects round-half-up instead of truncation in the twiddle product.
module fft_butterfly
  import top_fft_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int FRAC   = 15,
  parameter int TW_RE  = 32768,
  parameter int TW_IM  = 0,
  parameter bit TW_ONE = 1'b1
) (
  input  logic signed [IN_W-1:0] i_a_re,
  input  logic signed [IN_W-1:0] i_a_im,
  input  logic signed [IN_W-1:0] i_b_re,
  input  logic signed [IN_W-1:0] i_b_im,
  output logic signed [IN_W:0]   o_a_re,
  output logic signed [IN_W:0]   o_a_im,
  output logic signed [IN_W:0]   o_b_re,
  output logic signed [IN_W:0]   o_b_im
);

  logic signed [IN_W:0] w_wb_re;
  logic signed [IN_W:0] w_wb_im;

  if (TW_ONE) begin : g_bypass
    assign w_wb_re = {i_b_re[IN_W-1], i_b_re};
    assign w_wb_im = {i_b_im[IN_W-1], i_b_im};
  end else begin : g_mult
    localparam int TW_W   = FRAC + 2;
    localparam int PROD_W = IN_W + TW_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam logic signed [TW_W-1:0] W_RE = TW_W'(TW_RE);
    localparam logic signed [TW_W-1:0] W_IM = TW_W'(TW_IM);
`ifdef TOP_FFT_ROUND_EN
    localparam logic signed [SUM_W-1:0] RND = {{(SUM_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
`else
    localparam logic signed [SUM_W-1:0] RND = '0;
`endif
    logic signed [PROD_W-1:0] w_p_rr;
    logic signed [PROD_W-1:0] w_p_ii;
    logic signed [PROD_W-1:0] w_p_ri;
    logic signed [PROD_W-1:0] w_p_ir;
    logic signed [SUM_W-1:0]  w_sum_re;
    logic signed [SUM_W-1:0]  w_sum_im;
    logic                     w_unused;

    assign w_p_rr   = PROD_W'(i_b_re) * PROD_W'(W_RE);
    assign w_p_ii   = PROD_W'(i_b_im) * PROD_W'(W_IM);
    assign w_p_ri   = PROD_W'(i_b_re) * PROD_W'(W_IM);
    assign w_p_ir   = PROD_W'(i_b_im) * PROD_W'(W_RE);
    assign w_sum_re = SUM_W'(w_p_rr) - SUM_W'(w_p_ii) + RND;
    assign w_sum_im = SUM_W'(w_p_ri) + SUM_W'(w_p_ir) + RND;

    // Bit slice is the >>> FRAC plus truncation back to IN_W+1 bits
    assign w_wb_re  = w_sum_re[FRAC +: IN_W+1];
    assign w_wb_im  = w_sum_im[FRAC +: IN_W+1];
    assign w_unused = ^{w_sum_re[SUM_W-1:FRAC+IN_W+1], w_sum_re[FRAC-1:0],
                        w_sum_im[SUM_W-1:FRAC+IN_W+1], w_sum_im[FRAC-1:0]};
  end

  assign o_a_re = {i_a_re[IN_W-1], i_a_re} + w_wb_re;
  assign o_a_im = {i_a_im[IN_W-1], i_a_im} + w_wb_im;
  assign o_b_re = {i_a_re[IN_W-1], i_a_re} - w_wb_re;
  assign o_b_im = {i_a_im[IN_W-1], i_a_im} - w_wb_im;

endmodule

// File: rtl/top_fft.sv
// Fully parallel pipelined radix-2 DIT FFT: input register plus one registered rank
// per stage, one frame per clock. Build option TOP_FFT_ROUND_EN (see fft_butterfly).
module top_fft
  import top_fft_pkg::*;
#(
  parameter int POINT_FFT_POW2 = DEF_POINT_FFT_POW2,
  parameter int FRAC_BITS      = DEF_FRAC_BITS
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  top_fft_if.slave   bus
);

  localparam int N    = 1 << POINT_FFT_POW2;
  localparam int DIN  = data_in_w(FRAC_BITS);
  localparam int DOUT = data_out_w(FRAC_BITS, POINT_FFT_POW2);

  logic [N-1:0][1:0][DIN-1:0] r_in;
  logic [POINT_FFT_POW2:0]    r_valid;

  // Input frame register and the valid shift chain that tracks it through the ranks
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_in    <= '0;
      r_valid <= '0;
    end else begin
      r_in    <= bus.data_i;
      r_valid <= {r_valid[POINT_FFT_POW2-1:0], bus.valid_i};
    end
  end

  for (genvar s = 0; s < POINT_FFT_POW2; s++) begin : g_rank
    localparam int IW = DIN + s;
    localparam int H  = 1 << s;

    logic [N-1:0][IW-1:0]       w_x_re;
    logic [N-1:0][IW-1:0]       w_x_im;
    logic [N-1:0][IW:0]         w_y_re;
    logic [N-1:0][IW:0]         w_y_im;
    logic [N-1:0][1:0][IW:0]    r_data;

    for (genvar n = 0; n < N; n++) begin : g_src
      if (s == 0) begin : g_first
        assign w_x_re[n] = r_in[bit_reverse(n, POINT_FFT_POW2)][0];
        assign w_x_im[n] = r_in[bit_reverse(n, POINT_FFT_POW2)][1];
      end else begin : g_next
        assign w_x_re[n] = g_rank[s-1].r_data[n][0];
        assign w_x_im[n] = g_rank[s-1].r_data[n][1];
      end
    end

    // Butterfly b pairs I with I+H inside its 2H-point group; twiddle index is its offset M
    for (genvar b = 0; b < N / 2; b++) begin : g_bf
      localparam int M = b % H;
      localparam int I = (b / H) * 2 * H + M;

      fft_butterfly #(
        .IN_W   (IW),
        .FRAC   (FRAC_BITS),
        .TW_RE  (twiddle_re(M, 2 * H, FRAC_BITS)),
        .TW_IM  (twiddle_im(M, 2 * H, FRAC_BITS)),
        .TW_ONE (M == 0)
      ) u_bf (
        .i_a_re (w_x_re[I]),
        .i_a_im (w_x_im[I]),
        .i_b_re (w_x_re[I+H]),
        .i_b_im (w_x_im[I+H]),
        .o_a_re (w_y_re[I]),
        .o_a_im (w_y_im[I]),
        .o_b_re (w_y_re[I+H]),
        .o_b_im (w_y_im[I+H])
      );
    end

    // Rank output register; loads every cycle, validity comes from r_valid
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_data <= '0;
      end else begin
        for (int n = 0; n < N; n++) begin
          r_data[n][0] <= w_y_re[n];
          r_data[n][1] <= w_y_im[n];
        end
      end
    end
  end

  assign bus.data_o  = g_rank[POINT_FFT_POW2-1].r_data;
  assign bus.valid_o = r_valid[POINT_FFT_POW2];

endmodule

// File: tb/tb_top_fft.sv
// Scoreboard bench for top_fft: stimulus pushes the direct-DFT expectation, a negedge
// monitor pops and compares each presented spectrum (value within tolerance and latency).
module tb_top_fft;
  import top_fft_pkg::*;

  localparam int  P      = DEF_POINT_FFT_POW2;
  localparam int  FB     = DEF_FRAC_BITS;
  localparam int  N      = 1 << P;
  localparam int  DIN    = data_in_w(FB);
  localparam int  DOUT   = data_out_w(FB, P);
  localparam int  LAT    = P + 1;
  localparam int  TOL    = P + 1;
  localparam real TWO_PI = 6.283185307179586;

  typedef logic [N-1:0][1:0][DOUT-1:0] spec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   f_re [N];
  int   f_im [N];
  spec_t exp_q [$];
  int    cyc_q [$];
  int    tol_q [$];

  top_fft_if bus_if ();

  top_fft u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  // Drive the frame in f_re/f_im for one cycle and queue its ideal DFT
  task automatic issue(input int tol);
    spec_t ev;
    real   sr;
    real   si;
    real   ang;
    for (int k = 0; k < N; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < N; n++) begin
        ang = TWO_PI * real'((k * n) % N) / real'(N);
        sr  = sr + real'(f_re[n]) * $cos(ang) + real'(f_im[n]) * $sin(ang);
        si  = si + real'(f_im[n]) * $cos(ang) - real'(f_re[n]) * $sin(ang);
      end
      ev[k][0] = DOUT'(rnd(sr));
      ev[k][1] = DOUT'(rnd(si));
    end
    for (int n = 0; n < N; n++) begin
      bus_if.data_i[n][0] = DIN'(f_re[n]);
      bus_if.data_i[n][1] = DIN'(f_im[n]);
    end
    bus_if.valid_i = 1'b1;
    exp_q.push_back(ev);
    cyc_q.push_back(cyc + LAT);
    tol_q.push_back(tol);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    bus_if.valid_i = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      for (int n = 0; n < N; n++) begin
        bus_if.data_i[n][0] = DIN'($urandom);
        bus_if.data_i[n][1] = DIN'($urandom);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_random();
    for (int n = 0; n < N; n++) begin
      f_re[n] = int'($urandom_range(32'd32768)) - 16384;
      f_im[n] = int'($urandom_range(32'd32768)) - 16384;
    end
  endtask

  task automatic check_cleared(input string name);
    checks++;
    if (bus_if.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s valid_o got %b want 0", name, bus_if.valid_o);
    end
    checks++;
    if (bus_if.data_o !== '0) begin
      errors++;
      $display("FAIL %s data_o got %h want 0", name, bus_if.data_o);
    end
  endtask

  // Monitor: every presented spectrum must match the head of the scoreboard
  initial begin
    spec_t ev;
    int    oc;
    int    tol;
    int    got;
    int    want;
    int    d;
    int    bad;
    int    bg;
    int    bw;
    forever begin
      @(negedge clk);
      if (bus_if.valid_o === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid at cycle %0d got valid_o=1 want 0", cyc);
        end else begin
          ev  = exp_q.pop_front();
          oc  = cyc_q.pop_front();
          tol = tol_q.pop_front();
          bad = -1;
          bg  = 0;
          bw  = 0;
          for (int k = 0; k < N; k++) begin
            for (int c = 0; c < 2; c++) begin
              got  = int'($signed(bus_if.data_o[k][c]));
              want = int'($signed(ev[k][c]));
              d    = (got > want) ? got - want : want - got;
              if (d > tol && bad < 0) begin
                bad = k * 2 + c;
                bg  = got;
                bw  = want;
              end
            end
          end
          if (bad >= 0) begin
            errors++;
            $display("FAIL spectrum bin %0d %s got %0d want %0d tol %0d", bad / 2,
                     (bad % 2 == 1) ? "im" : "re", bg, bw, tol);
          end
          checks++;
          if (cyc != oc) begin
            errors++;
            $display("FAIL latency got output cycle %0d want cycle %0d", cyc, oc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.valid_i = 1'b0;
    bus_if.data_i  = '0;
    rst_n          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset_init");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // DC at 0.5
    for (int n = 0; n < N; n++) begin
      f_re[n] = 16384;
      f_im[n] = 0;
    end
    issue(TOL);
    idle(2);

    // Cosine at bin 3
    for (int n = 0; n < N; n++) begin
      f_re[n] = rnd(16384.0 * $cos(TWO_PI * real'(3 * n) / real'(N)));
      f_im[n] = 0;
    end
    issue(TOL);

    // Impulse: flat spectrum, exact
    for (int n = 0; n < N; n++) begin
      f_re[n] = (n == 0) ? 16384 : 0;
      f_im[n] = 0;
    end
    issue(0);

    // Full-scale negative DC: bin0 reaches -16.0 without wrap, exact
    for (int n = 0; n < N; n++) begin
      f_re[n] = -32768;
      f_im[n] = 0;
    end
    issue(0);
    idle(6);

    // Three distinct frames back to back
    for (int i = 0; i < 3; i++) begin
      load_random();
      issue(TOL);
    end
    idle(6);

    // Random frames with random gaps
    for (int i = 0; i < 20; i++) begin
      load_random();
      issue(TOL);
      idle(int'($urandom_range(32'd2)));
    end
    idle(LAT + 3);

    // Reset with two frames in flight
    load_random();
    issue(TOL);
    load_random();
    issue(TOL);
    bus_if.valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    tol_q.delete();
    #1;
    check_cleared("reset_mid");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(LAT + 5);

    load_random();
    issue(TOL);
    idle(LAT + 3);

    for (int i = 0; i < 4 * LAT && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending spectra got %0d want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
